// File: rtl/ppm_freq_lock_ctrl.sv
// PPM frequency-recovery loop controller: steps the clock-tuning DAC toward the
// target preamble pulse spacing and declares lock after a run of good measurements.
module ppm_freq_lock_ctrl #(
    parameter  int SYMBOL_CHIPS   = 16,
    parameter  int TARGET_SPACING = 8,
    parameter  int TOL            = 0,
    parameter  int COARSE_THRESH  = 3,
    parameter  int COARSE_STEP    = 4,
    parameter  int DAC_BITS       = 6,
    parameter  int DAC_INIT       = 32,
    parameter  int LOCK_COUNT     = 4,
    parameter  int TIMEOUT        = 1023,
    localparam int CW             = $clog2(SYMBOL_CHIPS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                restart,
    input  logic                meas_valid,
    input  logic [CW:0]         interpulse_cycles,
    input  logic [1:0]          intrasymbol_pulses,
    output logic [DAC_BITS-1:0] dac_code,
    output logic                freq_ok,
    output logic                timeout,
    output logic [2:0]          good_count,
    output logic [1:0]          CTRL_state_SC
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = DAC_BITS + 2;
    localparam int EW = CW + 2;

    localparam logic [TW-1:0]       TIMER_MAX = TW'(TIMEOUT);
    localparam logic [DW-1:0]       DAC_MAX   = DW'((1 << DAC_BITS) - 1);
    localparam logic [DAC_BITS-1:0] DAC_RST   = DAC_BITS'(DAC_INIT);
    localparam logic [2:0]          LOCK_N    = 3'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SEARCH = 2'b01,
        S_LOCKED = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [DAC_BITS-1:0] dac_q, dac_d;
    logic [2:0]          good_q, good_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                tmo_q, tmo_d;
    logic                ok_q;

    logic signed [EW-1:0] err;
    logic [EW-1:0]        abs_err;
    logic                 qual;
    logic                 in_tol;
    logic                 coarse;
    logic                 err_pos;
    logic [2:0]           good_inc;
    logic [DW-1:0]        dac_ext;
    logic [DW-1:0]        step;
    logic [DW-1:0]        dac_sum;
    logic [DAC_BITS-1:0]  dac_up;
    logic [DAC_BITS-1:0]  dac_dn;

    assign qual = meas_valid && (intrasymbol_pulses == 2'd2);

    // Error is widened by one sign bit so the full input range never overflows.
    assign err     = $signed({1'b0, interpulse_cycles}) - $signed(EW'(TARGET_SPACING));
    assign abs_err = err[EW-1] ? EW'(-err) : EW'(err);
    assign in_tol  = int'(abs_err) <= TOL;
    assign coarse  = int'(abs_err) > COARSE_THRESH;
    assign err_pos = err > 0;

    assign good_inc = (good_q == 3'd7) ? 3'd7 : good_q + 3'd1;

    assign dac_ext = DW'(dac_q);
    assign step    = coarse ? DW'(COARSE_STEP) : DW'(1);
    assign dac_sum = dac_ext + step;
    assign dac_up  = (dac_sum > DAC_MAX) ? DAC_BITS'(DAC_MAX) : DAC_BITS'(dac_sum);
    assign dac_dn  = (dac_ext >= step) ? DAC_BITS'(dac_ext - step) : '0;

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        good_d  = good_q;
        timer_d = timer_q;
        tmo_d   = tmo_q;
        if (restart) begin
            state_d = enable ? S_SEARCH : S_IDLE;
            dac_d   = DAC_RST;
            good_d  = '0;
            timer_d = '0;
            tmo_d   = 1'b0;
        end else if (!enable) begin
            state_d = S_IDLE;
            good_d  = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SEARCH;
                    timer_d = '0;
                end
                S_SEARCH: begin
                    if (qual) begin
                        timer_d = '0;
                        if (in_tol) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_N) begin
                                state_d = S_LOCKED;
                            end
                        end else begin
                            good_d = '0;
                            dac_d  = err_pos ? dac_dn : dac_up;
                        end
                    end else if (timer_q != TIMER_MAX) begin
                        timer_d = timer_q + 1'b1;
                        if (timer_d == TIMER_MAX) begin
                            tmo_d = 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            dac_q   <= DAC_RST;
            good_q  <= '0;
            timer_q <= '0;
            tmo_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            good_q  <= good_d;
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
            ok_q    <= (state_d == S_LOCKED);
        end
    end

    assign dac_code      = dac_q;
    assign freq_ok       = ok_q;
    assign timeout       = tmo_q;
    assign good_count    = good_q;
    assign CTRL_state_SC = state_q;

endmodule

// File: tb/tb_ppm_freq_lock_ctrl.sv
// Self-checking bench for ppm_freq_lock_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the loop rules.
module tb_ppm_freq_lock_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic       meas_valid = 1'b0;
    logic [4:0] interpulse_cycles = '0;
    logic [1:0] intrasymbol_pulses = '0;
    logic [5:0] dac_code;
    logic       freq_ok;
    logic       timeout;
    logic [2:0] good_count;
    logic [1:0] CTRL_state_SC;

    int n_chk = 0;
    int n_pass = 0;

    // Model: state 0 idle, 1 searching, 2 locked
    int m_st, m_dac, m_good, m_timer;
    bit m_tmo;

    ppm_freq_lock_ctrl dut (
        .clk                (clk),
        .resetn             (resetn),
        .enable             (enable),
        .restart            (restart),
        .meas_valid         (meas_valid),
        .interpulse_cycles  (interpulse_cycles),
        .intrasymbol_pulses (intrasymbol_pulses),
        .dac_code           (dac_code),
        .freq_ok            (freq_ok),
        .timeout            (timeout),
        .good_count         (good_count),
        .CTRL_state_SC      (CTRL_state_SC)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_dac = 32; m_good = 0; m_timer = 0; m_tmo = 0;
    endfunction

    function automatic void model_step();
        int e, st;
        if (!resetn) begin
            model_reset();
        end else if (restart) begin
            m_st = enable ? 1 : 0; m_dac = 32; m_good = 0; m_timer = 0; m_tmo = 0;
        end else if (!enable) begin
            m_st = 0; m_good = 0; m_timer = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_timer = 0;
        end else if (m_st == 1) begin
            if (meas_valid && intrasymbol_pulses == 2) begin
                m_timer = 0;
                e = int'(interpulse_cycles) - 8;
                if (iabs(e) <= 0) begin
                    m_good = (m_good + 1 > 7) ? 7 : m_good + 1;
                    if (m_good == 4) m_st = 2;
                end else begin
                    m_good = 0;
                    st = (iabs(e) > 3) ? 4 : 1;
                    if (e > 0) m_dac = (m_dac - st < 0) ? 0 : m_dac - st;
                    else m_dac = (m_dac + st > 63) ? 63 : m_dac + st;
                end
            end else begin
                m_timer = (m_timer + 1 > 1023) ? 1023 : m_timer + 1;
                if (m_timer == 1023) m_tmo = 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic meas(input int ipc, input int pulses);
        meas_valid = 1'b1;
        interpulse_cycles = 5'(ipc);
        intrasymbol_pulses = 2'(pulses);
        tick();
        meas_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        #22;
        n_chk++; if (dac_code !== 6'd32) $display("FAIL rst_dac got %0d want 32", dac_code); else n_pass++;
        n_chk++; if (freq_ok !== 1'b0) $display("FAIL rst_ok got %b want 0", freq_ok); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL rst_tmo got %b want 0", timeout); else n_pass++;
        n_chk++; if (good_count !== 3'd0) $display("FAIL rst_good got %0d want 0", good_count); else n_pass++;
        n_chk++; if (CTRL_state_SC !== 2'b00) $display("FAIL rst_state got %b want 00", CTRL_state_SC); else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_lock();
        enable = 1'b1;
        tick();
        n_chk++; if (CTRL_state_SC !== 2'b01) $display("FAIL t1_search got %b want 01", CTRL_state_SC); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            meas(8, 2);
            n_chk++; if (int'(good_count) !== i) $display("FAIL t1_good got %0d want %0d", good_count, i); else n_pass++;
            n_chk++; if (freq_ok !== (i == 4)) $display("FAIL t1_ok got %b want %b", freq_ok, i == 4); else n_pass++;
        end
        n_chk++; if (CTRL_state_SC !== 2'b10) $display("FAIL t1_locked got %b want 10", CTRL_state_SC); else n_pass++;
        n_chk++; if (dac_code !== 6'd32) $display("FAIL t1_dac got %0d want 32", dac_code); else n_pass++;
    endtask

    task automatic test_locked_ignore();
        meas(15, 2);
        n_chk++; if (dac_code !== 6'd32) $display("FAIL t6_dac got %0d want 32", dac_code); else n_pass++;
        n_chk++; if (freq_ok !== 1'b1) $display("FAIL t6_ok got %b want 1", freq_ok); else n_pass++;
        restart = 1'b1;
        meas(15, 2);
        restart = 1'b0;
        n_chk++; if (CTRL_state_SC !== 2'b01) $display("FAIL t6_state got %b want 01", CTRL_state_SC); else n_pass++;
        n_chk++; if (freq_ok !== 1'b0) $display("FAIL t6_ok0 got %b want 0", freq_ok); else n_pass++;
        n_chk++; if (good_count !== 3'd0) $display("FAIL t6_good got %0d want 0", good_count); else n_pass++;
        tick();
        n_chk++; if (dac_code !== 6'd32) $display("FAIL t6_drop got %0d want 32", dac_code); else n_pass++;
    endtask

    task automatic test_steps();
        meas(13, 2);
        n_chk++; if (dac_code !== 6'd28) $display("FAIL t2_coarse got %0d want 28", dac_code); else n_pass++;
        meas(10, 2);
        n_chk++; if (dac_code !== 6'd27) $display("FAIL t2_fine_dn got %0d want 27", dac_code); else n_pass++;
        meas(6, 2);
        n_chk++; if (dac_code !== 6'd28) $display("FAIL t2_fine_up got %0d want 28", dac_code); else n_pass++;
        n_chk++; if (good_count !== 3'd0) $display("FAIL t2_good got %0d want 0", good_count); else n_pass++;
    endtask

    task automatic test_ignore();
        meas(8, 2);
        n_chk++; if (good_count !== 3'd1) $display("FAIL t4_good1 got %0d want 1", good_count); else n_pass++;
        for (int p = 0; p < 4; p++) begin
            if (p == 2) continue;
            meas(15 - p * 4, p);
            n_chk++; if (dac_code !== 6'd28) $display("FAIL t4_dac p%0d got %0d want 28", p, dac_code); else n_pass++;
            n_chk++; if (good_count !== 3'd1) $display("FAIL t4_good p%0d got %0d want 1", p, good_count); else n_pass++;
        end
    endtask

    task automatic test_clamp();
        do_restart();
        repeat (7) meas(13, 2);
        repeat (3) meas(10, 2);
        n_chk++; if (dac_code !== 6'd1) $display("FAIL t3_one got %0d want 1", dac_code); else n_pass++;
        meas(15, 2);
        n_chk++; if (dac_code !== 6'd0) $display("FAIL t3_lo got %0d want 0", dac_code); else n_pass++;
        meas(15, 2);
        n_chk++; if (dac_code !== 6'd0) $display("FAIL t3_lo2 got %0d want 0", dac_code); else n_pass++;
        repeat (15) meas(2, 2);
        repeat (2) meas(6, 2);
        n_chk++; if (dac_code !== 6'd62) $display("FAIL t3_62 got %0d want 62", dac_code); else n_pass++;
        meas(2, 2);
        n_chk++; if (dac_code !== 6'd63) $display("FAIL t3_hi got %0d want 63", dac_code); else n_pass++;
        meas(2, 2);
        n_chk++; if (dac_code !== 6'd63) $display("FAIL t3_hi2 got %0d want 63", dac_code); else n_pass++;
    endtask

    task automatic test_enable_low();
        do_restart();
        meas(13, 2);
        meas(8, 2);
        meas(8, 2);
        enable = 1'b0;
        tick();
        n_chk++; if (CTRL_state_SC !== 2'b00) $display("FAIL en_state got %b want 00", CTRL_state_SC); else n_pass++;
        n_chk++; if (good_count !== 3'd0) $display("FAIL en_good got %0d want 0", good_count); else n_pass++;
        n_chk++; if (dac_code !== 6'd28) $display("FAIL en_dac got %0d want 28", dac_code); else n_pass++;
        enable = 1'b1;
        tick();
        n_chk++; if (CTRL_state_SC !== 2'b01 || dac_code !== 6'd28)
            $display("FAIL en_resume got %b/%0d want 01/28", CTRL_state_SC, dac_code); else n_pass++;
    endtask

    task automatic test_timeout();
        do_restart();
        repeat (1000) tick();
        n_chk++; if (timeout !== 1'b0) $display("FAIL t5_early got %b want 0", timeout); else n_pass++;
        repeat (30) tick();
        n_chk++; if (timeout !== 1'b1) $display("FAIL t5_set got %b want 1", timeout); else n_pass++;
        meas(8, 2);
        repeat (5) tick();
        n_chk++; if (timeout !== 1'b1) $display("FAIL t5_sticky got %b want 1", timeout); else n_pass++;
        n_chk++; if (good_count !== 3'd1) $display("FAIL t5_loop got %0d want 1", good_count); else n_pass++;
        meas(12, 2);
        do_restart();
        n_chk++; if (timeout !== 1'b0) $display("FAIL t5_clr got %b want 0", timeout); else n_pass++;
        n_chk++; if (dac_code !== 6'd32) $display("FAIL t5_dac got %0d want 32", dac_code); else n_pass++;
    endtask

    task automatic test_async_reset();
        meas(13, 2);
        meas(8, 2);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        n_chk++; if (dac_code !== 6'd32 || good_count !== 3'd0 || CTRL_state_SC !== 2'b00)
            $display("FAIL async_rst got %0d/%0d/%b want 32/0/00", dac_code, good_count, CTRL_state_SC); else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int ipc;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 60) != 0;
            restart = ($urandom % 90) == 0;
            meas_valid = ($urandom % 3) == 0;
            intrasymbol_pulses = (($urandom % 4) == 0) ? 2'($urandom % 4) : 2'd2;
            ipc = (($urandom % 2) == 0) ? 6 + int'($urandom % 5) : int'($urandom % 32);
            interpulse_cycles = 5'(ipc);
            tick();
            n_chk++;
            if (int'(dac_code) !== m_dac || int'(good_count) !== m_good ||
                int'(CTRL_state_SC) !== m_st || freq_ok !== (m_st == 2) || timeout !== m_tmo) begin
                $display("FAIL rnd_%0d got dac=%0d good=%0d st=%0d ok=%b tmo=%b want dac=%0d good=%0d st=%0d ok=%b tmo=%b",
                         i, dac_code, good_count, CTRL_state_SC, freq_ok, timeout,
                         m_dac, m_good, m_st, m_st == 2, m_tmo);
            end else begin
                n_pass++;
            end
        end
        restart = 1'b0;
        meas_valid = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_locked_ignore();
        test_steps();
        test_ignore();
        test_clamp();
        test_enable_low();
        test_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
